// File: rtl/wbs_pkg.sv
// rtl/wbs_pkg.sv - shared state enum and default sizing for the weight bit sequencer
package wbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } wbs_state_e;

  localparam int WBS_DATA_WIDTH  = 8;
  localparam int WBS_VEC_LENGTH  = 16;
  localparam int WBS_NUM_COLUMNS = WBS_DATA_WIDTH;

endpackage

// File: rtl/sign_mag_convert.sv
// rtl/sign_mag_convert.sv - combinational two's-complement to sign/magnitude for one lane
module sign_mag_convert #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude
);

  // The most negative value maps onto itself, which reads as 2^(WIDTH-1) unsigned.
  always_comb begin
    sign      = value[WIDTH-1];
    magnitude = value[WIDTH-1] ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/weight_bit_sequencer.sv
// rtl/weight_bit_sequencer.sv - streams sign/magnitude weight bit columns to a bit-serial MAC
// Optional feature: WBS_ZERO_SKIP_EN skips columns that are zero in every lane.
module weight_bit_sequencer
  import wbs_pkg::*;
#(
  parameter int DATA_WIDTH = WBS_DATA_WIDTH,
  parameter int VEC_LENGTH = WBS_VEC_LENGTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  w_valid,
  output logic                                  w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in,
  input  logic                                  w_load,
  output logic [VEC_LENGTH-1:0]                 sign,
  output logic [VEC_LENGTH-1:0]                 w_bit,
  output logic [$clog2(DATA_WIDTH)-1:0]         column_idx,
  output logic                                  en,
  output logic                                  load_accum,
  output logic                                  vec_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] conv_mag;
  logic [VEC_LENGTH-1:0]                 conv_sign;

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    sign_mag_convert #(.WIDTH(DATA_WIDTH)) u_conv (
      .value     (w_in[j]),
      .sign      (conv_sign[j]),
      .magnitude (conv_mag[j])
    );
  end

  wbs_state_e                            state_q, state_d;
  logic [CW-1:0]                         col_q, col_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] mag_q, mag_d;
  logic [VEC_LENGTH-1:0]                 sign_q, sign_d;
  logic [VEC_LENGTH-1:0]                 w_bit_q, w_bit_d;
  logic [CW-1:0]                         column_idx_q, column_idx_d;
  logic                                  en_q, en_d;
  logic                                  load_accum_q, load_accum_d;
  logic                                  vec_done_q, vec_done_d;
  logic                                  w_ready_q, w_ready_d;

  logic [DATA_WIDTH-1:0] col_mask;
  logic                  search;
  logic                  found;
  logic [CW-1:0]         nxt;
  int                    lo;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    mag_d        = mag_q;
    sign_d       = sign_q;
    en_d         = 1'b0;
    load_accum_d = 1'b0;
    vec_done_d   = 1'b0;
    w_bit_d      = '0;
    column_idx_d = '0;
    search       = 1'b0;
    lo           = 0;

    case (state_q)
      ST_IDLE: begin
        if (w_valid) begin
          mag_d  = conv_mag;
          sign_d = conv_sign;
          if (w_load) begin
            state_d      = ST_LOAD;
            load_accum_d = 1'b1;
          end else begin
            search = 1'b1;
          end
        end
      end
      ST_LOAD: search = 1'b1;
      ST_RUN: begin
        search = 1'b1;
        lo     = int'(col_q) + 1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef WBS_ZERO_SKIP_EN
    col_mask = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      col_mask = col_mask | mag_d[j];
    end
`else
    col_mask = '1;
`endif

    // Lowest column at or above lo that still carries a set bit.
    found = 1'b0;
    nxt   = '0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (col_mask[c] && (c >= lo)) begin
        found = 1'b1;
        nxt   = CW'(c);
      end
    end

    if (search) begin
      if (found) begin
        state_d      = ST_RUN;
        col_d        = nxt;
        en_d         = 1'b1;
        column_idx_d = nxt;
        for (int j = 0; j < VEC_LENGTH; j++) begin
          w_bit_d[j] = mag_d[j][nxt];
        end
      end else if (state_q == ST_IDLE) begin
        // An empty vector taken straight into RUN still spends one idle RUN cycle.
        state_d = ST_RUN;
        col_d   = '0;
      end else begin
        state_d    = ST_DONE;
        vec_done_d = 1'b1;
      end
    end

    w_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      mag_q        <= '0;
      sign_q       <= '0;
      w_bit_q      <= '0;
      column_idx_q <= '0;
      en_q         <= 1'b0;
      load_accum_q <= 1'b0;
      vec_done_q   <= 1'b0;
      w_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      mag_q        <= mag_d;
      sign_q       <= sign_d;
      w_bit_q      <= w_bit_d;
      column_idx_q <= column_idx_d;
      en_q         <= en_d;
      load_accum_q <= load_accum_d;
      vec_done_q   <= vec_done_d;
      w_ready_q    <= w_ready_d;
    end
  end

  assign w_ready    = w_ready_q;
  assign sign       = sign_q;
  assign w_bit      = w_bit_q;
  assign column_idx = column_idx_q;
  assign en         = en_q;
  assign load_accum = load_accum_q;
  assign vec_done   = vec_done_q;

endmodule

// File: tb/tb_weight_bit_sequencer.sv
// tb/tb_weight_bit_sequencer.sv - directed self-checking bench for weight_bit_sequencer
module tb_weight_bit_sequencer;

  localparam int DW = 8;
  localparam int VL = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               w_valid = 1'b0;
  logic               w_load = 1'b0;
  logic [VL-1:0][DW-1:0] w_in = '0;
  logic               w_ready;
  logic [VL-1:0]      sign;
  logic [VL-1:0]      w_bit;
  logic [2:0]         column_idx;
  logic               en;
  logic               load_accum;
  logic               vec_done;

  int checks = 0;
  int failures = 0;

  // {w_ready, en, load_accum, vec_done, column_idx, w_bit, sign}
  logic [38:0] obs;
  assign obs = {w_ready, en, load_accum, vec_done, column_idx, w_bit, sign};

  always #5 clk = ~clk;

  weight_bit_sequencer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_in       (w_in),
    .w_load     (w_load),
    .sign       (sign),
    .w_bit      (w_bit),
    .column_idx (column_idx),
    .en         (en),
    .load_accum (load_accum),
    .vec_done   (vec_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [38:0] exp;
    exp = {1'b1, 38'h0};
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_hold actual=%h expected=%h", obs, exp);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release actual=%h expected=%h", obs, exp);
    end
  endtask

  task automatic test_plus3();
    logic [38:0] exp;
    for (int j = 0; j < VL; j++) w_in[j] = 8'd3;
    w_load = 1'b0;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8)
        exp = {4'b0100, 3'(k - 1), (k <= 2) ? 16'hFFFF : 16'h0000, 16'h0000};
      else if (k == 9)
        exp = {4'b0001, 3'd0, 32'h0};
      else
        exp = {4'b1000, 35'h0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL plus3 k=%0d actual=%h expected=%h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_neg128_load();
    logic [38:0] exp;
    w_in = '0;
    w_in[0] = 8'h80;
    w_load = 1'b1;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    w_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1)
        exp = {4'b0010, 3'd0, 16'h0000, 16'h0001};
      else if (k <= 9)
        exp = {4'b0100, 3'(k - 2), (k == 9) ? 16'h0001 : 16'h0000, 16'h0001};
      else
        exp = {4'b0001, 3'd0, 16'h0000, 16'h0001};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL neg128 k=%0d actual=%h expected=%h", k, obs, exp);
      end
      tick();
    end
    checks++;
    if (w_ready !== 1'b1 || en !== 1'b0) begin
      failures++;
      $display("FAIL neg128_idle actual=%b%b expected=10", w_ready, en);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [38:0] exp;
    for (int j = 0; j < VL; j++) w_in[j] = 8'd7;
    w_load = 1'b0;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (en !== 1'b1 || column_idx !== 3'd3) begin
      failures++;
      $display("FAIL midrun_col3 actual=%b/%0d expected=1/3", en, column_idx);
    end
    reset = 1'b0;
    tick();
    exp = {1'b1, 38'h0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL midrun_reset actual=%h expected=%h", obs, exp);
    end
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (en !== 1'b0 || vec_done !== 1'b0) begin
        failures++;
        $display("FAIL midrun_quiet k=%0d actual=%b%b expected=00", k, en, vec_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VL-1:0][DW-1:0] vecs [3];
    logic [VL-1:0][DW-1:0] mag;
    logic [VL-1:0]         sgn;
    logic [VL-1:0]         bits;
    logic [38:0]           exp;
    logic [38:0]           msk;
    logic [7:0]            v;
    int                    c, ph, t;
    for (int j = 0; j < VL; j++) begin
      vecs[0][j] = 8'h5A;
      vecs[1][j] = 8'(j * 9 - 60);
      vecs[2][j] = 8'(128 + j * 3);
    end
    w_load = 1'b0;
    w_valid = 1'b1;
    for (int p = 0; p < 30; p++) begin
      if (p % 10 == 0)
        w_in = vecs[p / 10];
      else
        for (int j = 0; j < VL; j++) w_in[j] = 8'($urandom);
      tick();
      c = p + 1;
      ph = c % 10;
      t = (c - 1) / 10;
      for (int j = 0; j < VL; j++) begin
        v = vecs[t][j];
        sgn[j] = v[7];
        mag[j] = v[7] ? 8'(-v) : v;
      end
      msk = '1;
      if (ph >= 1 && ph <= 8) begin
        for (int j = 0; j < VL; j++) bits[j] = mag[j][ph - 1];
        exp = {4'b0100, 3'(ph - 1), bits, sgn};
      end else if (ph == 9) begin
        exp = {4'b0001, 3'd0, 16'h0000, sgn};
      end else begin
        exp = {4'b1000, 35'h0};
        msk = {23'h7FFFFF, 16'h0000};
      end
      checks++;
      if ((obs & msk) !== (exp & msk)) begin
        failures++;
        $display("FAIL b2b cycle=%0d actual=%h expected=%h", c, obs & msk, exp & msk);
      end
    end
    w_valid = 1'b0;
    tick();
    tick();
  endtask

`ifdef WBS_ZERO_SKIP_EN
  task automatic test_zero_skip();
    logic [38:0] exp;
    for (int j = 0; j < VL; j++) w_in[j] = 8'h11;
    w_load = 1'b0;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      case (k)
        1:       exp = {4'b0100, 3'd0, 16'hFFFF, 16'h0000};
        2:       exp = {4'b0100, 3'd4, 16'hFFFF, 16'h0000};
        3:       exp = {4'b0001, 3'd0, 32'h0};
        default: exp = {4'b1000, 35'h0};
      endcase
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL skip11 k=%0d actual=%h expected=%h", k, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_zero_vector();
    logic [38:0] exp;
    w_in = '0;
    w_load = 1'b0;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      case (k)
        1:       exp = 39'h0;
        2:       exp = {4'b0001, 35'h0};
        default: exp = {4'b1000, 35'h0};
      endcase
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL skipzero k=%0d actual=%h expected=%h", k, obs, exp);
      end
      tick();
    end
  endtask
`else
  task automatic test_zero_vector();
    logic [38:0] exp;
    w_in = '0;
    w_load = 1'b0;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8)
        exp = {4'b0100, 3'(k - 1), 32'h0};
      else if (k == 9)
        exp = {4'b0001, 35'h0};
      else
        exp = {4'b1000, 35'h0};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL zerovec k=%0d actual=%h expected=%h", k, obs, exp);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plus3();
    test_neg128_load();
    test_reset_mid_run();
    test_back_to_back();
`ifdef WBS_ZERO_SKIP_EN
    test_zero_skip();
`endif
    test_zero_vector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
